// File: rtl/fpga_mem_pkg.sv
// fpga_mem_pkg: shared types and sizing helpers for the FPGA BRAM bus sequencer.
//   state_e  - sequencer states
//   op_e     - transaction kind latched at grant time
//   DEF_*    - default geometry (32-bit beats, 8-beat lines)
//   line_w_f / cnt_w_f - sizing helpers for parameterised instances
package fpga_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WACK  = 3'd3,
    RWAIT = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned DEF_ADW     = 32'd32;
  localparam int unsigned DEF_BURST   = 32'd8;
  localparam int unsigned DEF_LINE_W  = DEF_ADW * DEF_BURST;
  localparam int unsigned DEF_CNT_W   = $clog2(DEF_BURST);

  // Width of one full line made of burst_len beats.
  function automatic int unsigned line_w_f(input int unsigned adw, input int unsigned burst_len);
    return adw * burst_len;
  endfunction

  // Beat counter width; a single-beat burst still needs one bit.
  function automatic int unsigned cnt_w_f(input int unsigned burst_len);
    if (burst_len > 32'd1) begin
      return $clog2(burst_len);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/fpga_mem_rr_arb.sv
// fpga_mem_rr_arb: two-way round-robin arbiter.
//   clk, rst_n  - clock, async active-low reset
//   req         - per-requester request level
//   done        - strobe marking completion of the granted transaction
//   done_idx    - index of the requester that just completed
//   grant_idx   - requester that wins if the sequencer arbitrates this cycle
//   any_req     - at least one requester is asking
// The pointer names the preferred requester; the other one wins only when the
// preferred one is idle. After a completion the other requester becomes preferred.
module fpga_mem_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_idx,
  output logic       grant_idx,
  output logic       any_req
);

  logic ptr_r;

  // Preference pointer: hand priority to the other requester after each completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (done) begin
      ptr_r <= ~done_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Grant decode: preferred requester first, otherwise whichever is asking.
  always_comb begin
    grant_idx = ptr_r;
    any_req   = |req;
    if (req[ptr_r]) begin
      grant_idx = ptr_r;
    end else if (req[~ptr_r]) begin
      grant_idx = ~ptr_r;
    end else begin
      grant_idx = ptr_r;
    end
  end

endmodule

// File: rtl/fpga_mem_arbiter.sv
// fpga_mem_arbiter: controller-side sequencer for the multiplexed BRAM address/data bus.
// Two requesters ask for whole lines; the winner's request becomes one address beat
// followed by BURST_LEN write beats (write) or BURST_LEN collected return beats (read).
// Ports:
//   fpga_clk, rst_n              clock, async active-low reset
//   req_read/req_write [2]       request levels, held until req_resp
//   req_addr  [2*ADW]            line address per requester
//   req_wdata [2*LINE_W]         write line per requester, beat i at [i*ADW +: ADW]
//   req_rdata [LINE_W]           last successfully read line
//   req_resp/req_err [2]         one-cycle completion pulse / failure flag
//   busy                         sequencer not idle
//   address_data_bus_c_to_m ...  outbound beat and its qualifiers, fifo_empty when none
//   address_data_bus_m_to_c      read-return beat
//   resp_m_to_c                  read beat valid / write acknowledge
//   r_en                         memory accepts the presented outbound beat
//   error                        memory-side abort
// All outputs are registered: the next-state decode produces next-output values that
// are captured on the same edge as the state change.
module fpga_mem_arbiter
  import fpga_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN          = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                                      fpga_clk,
  input  logic                                      rst_n,
  input  logic [1:0]                                req_read,
  input  logic [1:0]                                req_write,
  input  logic [2*ADDRESS_DATA_WIDTH-1:0]           req_addr,
  input  logic [2*ADDRESS_DATA_WIDTH*BURST_LEN-1:0] req_wdata,
  output logic [ADDRESS_DATA_WIDTH*BURST_LEN-1:0]   req_rdata,
  output logic [1:0]                                req_resp,
  output logic [1:0]                                req_err,
  output logic                                      busy,
  output logic [ADDRESS_DATA_WIDTH-1:0]             address_data_bus_c_to_m,
  output logic                                      address_on_c_to_m,
  output logic                                      data_on_c_to_m,
  output logic                                      read_en_c_to_m,
  output logic                                      write_en_c_to_m,
  output logic                                      fifo_empty,
  input  logic [ADDRESS_DATA_WIDTH-1:0]             address_data_bus_m_to_c,
  input  logic                                      resp_m_to_c,
  input  logic                                      r_en,
  input  logic                                      error
);

  localparam int unsigned ADW    = ADDRESS_DATA_WIDTH;
  localparam int unsigned LINE_W = line_w_f(ADDRESS_DATA_WIDTH, BURST_LEN);
  localparam int unsigned CNT_W  = cnt_w_f(BURST_LEN);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

  // Transaction context
  state_e              state_r, state_s;
  op_e                 op_r, op_s;
  logic                grant_r, grant_s;
  logic [ADW-1:0]      addr_r, addr_s;
  logic [LINE_W-1:0]   wdata_r, wdata_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [WD_W-1:0]     wd_r, wd_s;
  logic                err_r, err_s;
  logic [LINE_W-1:0]   rbuf_r, rbuf_s;
  logic                progress_s;

  // Arbiter interface
  logic [1:0]          req_any_s;
  logic                arb_grant_s;
  logic                arb_any_s;
  logic                done_s;

  // Next output values
  logic [ADW-1:0]      bus_s;
  logic                addr_on_s;
  logic                data_on_s;
  logic                rd_en_s;
  logic                wr_en_s;
  logic                fifo_empty_s;
  logic [1:0]          resp_s;
  logic [1:0]          rerr_s;
  logic                busy_s;
  logic [LINE_W-1:0]   rdata_s;

  assign req_any_s = req_read | req_write;
  assign done_s    = (state_r == DONE);

  fpga_mem_rr_arb u_rr_arb (
    .clk       (fpga_clk),
    .rst_n     (rst_n),
    .req       (req_any_s),
    .done      (done_s),
    .done_idx  (grant_r),
    .grant_idx (arb_grant_s),
    .any_req   (arb_any_s)
  );

  // Next-state and transaction-context decode, including watchdog and error abort.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    grant_s    = grant_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    cnt_s      = cnt_r;
    wd_s       = wd_r;
    err_s      = err_r;
    rbuf_s     = rbuf_r;
    progress_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          grant_s = arb_grant_s;
          // Write wins when a requester raises both levels at once.
          if (req_write[arb_grant_s]) begin
            op_s = OP_WR;
          end else begin
            op_s = OP_RD;
          end
          if (arb_grant_s) begin
            addr_s  = req_addr[2*ADW-1:ADW];
            wdata_s = req_wdata[2*LINE_W-1:LINE_W];
          end else begin
            addr_s  = req_addr[ADW-1:0];
            wdata_s = req_wdata[LINE_W-1:0];
          end
          cnt_s   = '0;
          err_s   = 1'b0;
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end

      ADDR: begin
        if (error) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else if (r_en) begin
          progress_s = 1'b1;
          if (op_r == OP_WR) begin
            state_s = WDATA;
          end else begin
            state_s = RWAIT;
          end
        end else begin
          state_s = ADDR;
        end
      end

      WDATA: begin
        if (error) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else if (r_en) begin
          progress_s = 1'b1;
          // Counter parks on the last beat rather than wrapping.
          if (cnt_r == LAST_BEAT) begin
            state_s = WACK;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = WDATA;
        end
      end

      WACK: begin
        if (error) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else if (resp_m_to_c) begin
          progress_s = 1'b1;
          state_s    = DONE;
        end else begin
          state_s = WACK;
        end
      end

      RWAIT: begin
        // error outranks a coincident return beat, so the beat is dropped.
        if (error) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else if (resp_m_to_c) begin
          progress_s = 1'b1;
          rbuf_s[cnt_r*ADW +: ADW] = address_data_bus_m_to_c;
          if (cnt_r == LAST_BEAT) begin
            state_s = DONE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = RWAIT;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Watchdog only runs while waiting on memory; any progress or abort clears it.
    if ((state_r == ADDR || state_r == WDATA || state_r == WACK || state_r == RWAIT)
        && !error && !progress_s) begin
      if (wd_r == WD_LIMIT) begin
        wd_s    = '0;
        err_s   = 1'b1;
        state_s = DONE;
      end else begin
        wd_s = wd_r + WD_W'(1);
      end
    end else begin
      wd_s = '0;
    end
  end

  // Next-output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    bus_s        = '0;
    addr_on_s    = 1'b0;
    data_on_s    = 1'b0;
    rd_en_s      = 1'b0;
    wr_en_s      = 1'b0;
    fifo_empty_s = 1'b1;
    resp_s       = 2'b00;
    rerr_s       = 2'b00;
    busy_s       = (state_s != IDLE);
    rdata_s      = req_rdata;

    case (state_s)
      ADDR: begin
        bus_s        = addr_s;
        addr_on_s    = 1'b1;
        rd_en_s      = (op_s == OP_RD);
        wr_en_s      = (op_s == OP_WR);
        fifo_empty_s = 1'b0;
      end
      WDATA: begin
        bus_s        = wdata_s[cnt_s*ADW +: ADW];
        data_on_s    = 1'b1;
        wr_en_s      = 1'b1;
        fifo_empty_s = 1'b0;
      end
      DONE: begin
        resp_s[grant_s] = 1'b1;
        rerr_s[grant_s] = err_s;
        // A failed read leaves the previously returned line visible.
        if (op_s == OP_RD && !err_s) begin
          rdata_s = rbuf_s;
        end else begin
          rdata_s = req_rdata;
        end
      end
      default: begin
        bus_s = '0;
      end
    endcase
  end

  // Transaction context registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= OP_RD;
      grant_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt_r   <= '0;
      wd_r    <= '0;
      err_r   <= 1'b0;
      rbuf_r  <= '0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      grant_r <= grant_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      cnt_r   <= cnt_s;
      wd_r    <= wd_s;
      err_r   <= err_s;
      rbuf_r  <= rbuf_s;
    end
  end

  // Output registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      address_data_bus_c_to_m <= '0;
      address_on_c_to_m       <= 1'b0;
      data_on_c_to_m          <= 1'b0;
      read_en_c_to_m          <= 1'b0;
      write_en_c_to_m         <= 1'b0;
      fifo_empty              <= 1'b1;
      req_resp                <= 2'b00;
      req_err                 <= 2'b00;
      busy                    <= 1'b0;
      req_rdata               <= '0;
    end else begin
      address_data_bus_c_to_m <= bus_s;
      address_on_c_to_m       <= addr_on_s;
      data_on_c_to_m          <= data_on_s;
      read_en_c_to_m          <= rd_en_s;
      write_en_c_to_m         <= wr_en_s;
      fifo_empty              <= fifo_empty_s;
      req_resp                <= resp_s;
      req_err                 <= rerr_s;
      busy                    <= busy_s;
      req_rdata               <= rdata_s;
    end
  end

endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// Scoreboard bench for fpga_mem_arbiter: stimulus pushes expected outbound beats and
// expected responses; a negedge memory/monitor process models the memory side and
// pops/compares whenever the DUT transfers a beat or pulses req_resp.
module tb_fpga_mem_arbiter;
  localparam int ADW = 32;
  localparam int BL  = 8;
  localparam int LW  = ADW * BL;
  localparam int TO  = 16;

  typedef struct packed {
    logic           a_on;
    logic           d_on;
    logic           rd;
    logic           wr;
    logic           last;
    logic [ADW-1:0] bus;
  } beat_t;

  typedef struct {
    int          port;
    logic        err;
    logic [LW-1:0] rdata;
  } resp_t;

  logic            fpga_clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_read, req_write;
  logic [2*ADW-1:0] req_addr;
  logic [2*LW-1:0] req_wdata;
  logic [LW-1:0]   req_rdata;
  logic [1:0]      req_resp, req_err;
  logic            busy;
  logic [ADW-1:0]  bus_c2m;
  logic            address_on, data_on, read_en, write_en, fifo_empty;
  logic [ADW-1:0]  bus_m2c;
  logic            resp_m2c, r_en, error;

  fpga_mem_arbiter #(
    .ADDRESS_DATA_WIDTH (ADW),
    .BURST_LEN          (BL),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .fpga_clk                (fpga_clk),
    .rst_n                   (rst_n),
    .req_read                (req_read),
    .req_write               (req_write),
    .req_addr                (req_addr),
    .req_wdata               (req_wdata),
    .req_rdata               (req_rdata),
    .req_resp                (req_resp),
    .req_err                 (req_err),
    .busy                    (busy),
    .address_data_bus_c_to_m (bus_c2m),
    .address_on_c_to_m       (address_on),
    .data_on_c_to_m          (data_on),
    .read_en_c_to_m          (read_en),
    .write_en_c_to_m         (write_en),
    .fifo_empty              (fifo_empty),
    .address_data_bus_m_to_c (bus_m2c),
    .resp_m_to_c             (resp_m2c),
    .r_en                    (r_en),
    .error                   (error)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  beat_t exp_beat[$];
  resp_t exp_resp[$];
  logic [ADW-1:0] rd_q[$];

  // memory-model controls, written by stimulus
  int ren_mode = 0;   // 0: r_en always 1, 1: r_en toggles
  int mute     = 0;   // suppress read returns
  int err_at   = -1;  // read beat index that carries error=1

  // memory-model state, owned by the monitor process
  int   rd_left = 0;
  int   rd_idx  = 0;
  logic wack_pend = 1'b0;
  logic tog = 1'b0;

  always @(posedge fpga_clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [ADW-1:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < BL; i++) l[i*ADW +: ADW] = base + ADW'(i);
    return l;
  endfunction

  // Memory model plus scoreboard monitor, all at the falling edge.
  always @(negedge fpga_clk) begin
    beat_t eb;
    resp_t er;
    logic [1:0] pm;
    if (!rst_n) begin
      rd_left = 0; rd_idx = 0; wack_pend = 1'b0; tog = 1'b0;
      r_en = 1'b0; resp_m2c = 1'b0; error = 1'b0; bus_m2c = '0;
    end else begin
      if (req_resp !== 2'b00) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", LW'(req_resp), LW'(0));
        end else begin
          er = exp_resp.pop_front();
          pm = 2'b01 << er.port;
          chk("resp_port", LW'(req_resp), LW'(pm));
          chk("resp_err", LW'(req_err), er.err ? LW'(pm) : LW'(0));
          chk("resp_rdata", req_rdata, er.rdata);
        end
        repeat (rd_left) if (rd_q.size() > 0) void'(rd_q.pop_front());
        rd_left = 0;
      end
      resp_m2c = 1'b0; error = 1'b0; bus_m2c = '0;
      if (rd_left > 0 && mute == 0) begin
        resp_m2c = 1'b1;
        if (rd_q.size() > 0) bus_m2c = rd_q.pop_front();
        else bus_m2c = 32'hDEAD_BEEF;
        if (rd_idx == err_at) error = 1'b1;
        rd_idx++;
        rd_left--;
      end else if (wack_pend) begin
        resp_m2c = 1'b1;
        wack_pend = 1'b0;
      end
      tog = ~tog;
      r_en = (ren_mode == 0) ? 1'b1 : tog;
      if (!fifo_empty && r_en) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_beat", LW'({address_on, data_on, read_en, write_en, bus_c2m}), LW'(0));
        end else begin
          eb = exp_beat.pop_front();
          chk("out_beat", LW'({address_on, data_on, read_en, write_en, bus_c2m}),
              LW'({eb.a_on, eb.d_on, eb.rd, eb.wr, eb.bus}));
          if (eb.rd && eb.a_on) begin rd_left = BL; rd_idx = 0; end
          if (eb.last) wack_pend = 1'b1;
        end
      end
    end
  end

  task automatic push_read(input int p, input logic [ADW-1:0] a, input logic [ADW-1:0] rbase,
                           input logic e, input logic [LW-1:0] line);
    beat_t b;
    resp_t r;
    b = '{a_on: 1'b1, d_on: 1'b0, rd: 1'b1, wr: 1'b0, last: 1'b0, bus: a};
    exp_beat.push_back(b);
    for (int i = 0; i < BL; i++) rd_q.push_back(rbase + ADW'(i));
    r.port = p; r.err = e; r.rdata = line;
    exp_resp.push_back(r);
  endtask

  task automatic push_write(input int p, input logic [ADW-1:0] a, input logic [ADW-1:0] wbase,
                            input logic [LW-1:0] line);
    beat_t b;
    resp_t r;
    b = '{a_on: 1'b1, d_on: 1'b0, rd: 1'b0, wr: 1'b1, last: 1'b0, bus: a};
    exp_beat.push_back(b);
    for (int i = 0; i < BL; i++) begin
      b = '{a_on: 1'b0, d_on: 1'b1, rd: 1'b0, wr: 1'b1, last: (i == BL - 1), bus: wbase + ADW'(i)};
      exp_beat.push_back(b);
    end
    r.port = p; r.err = 1'b0; r.rdata = line;
    exp_resp.push_back(r);
  endtask

  task automatic wait_resp(input int p, input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge fpga_clk);
      if (req_resp[p]) begin
        cyc = cycle;
        req_read[p] = 1'b0;
        req_write[p] = 1'b0;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL resp_timeout: port %0d got no req_resp within %0d cycles", p, budget);
    req_read[p] = 1'b0;
    req_write[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [LW-1:0] last_line;
    int c0, c1, n0, n1, k;
    int order[4];
    rst_n = 1'b0; req_read = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    r_en = 1'b0; resp_m2c = 1'b0; error = 1'b0; bus_m2c = '0;
    last_line = '0;
    repeat (3) @(negedge fpga_clk);
    chk("reset_outputs", LW'({busy, address_on, data_on, read_en, write_en, fifo_empty,
                              req_resp, req_err, bus_c2m}), LW'({6'b000001, 4'b0000, 32'h0}));
    chk("reset_rdata", req_rdata, LW'(0));
    rst_n = 1'b1;
    @(negedge fpga_clk);

    // 1: single read, back-to-back returns, minimum latency
    push_read(0, 32'h100, 32'hA0, 1'b0, mk_line(32'hA0));
    @(negedge fpga_clk);
    req_addr[ADW-1:0] = 32'h100; req_read[0] = 1'b1; c0 = cycle;
    wait_resp(0, 40, c1);
    chk("t1_latency", LW'(c1 - c0), LW'(10));
    last_line = mk_line(32'hA0);

    // 2: write on requester 1 with r_en toggling
    ren_mode = 1;
    push_write(1, 32'h180, 32'h10, last_line);
    @(negedge fpga_clk);
    req_addr[2*ADW-1:ADW] = 32'h180; req_wdata[2*LW-1:LW] = mk_line(32'h10); req_write[1] = 1'b1;
    wait_resp(1, 80, c1);
    chk("t2_all_beats_sent", LW'(exp_beat.size()), LW'(0));
    ren_mode = 0;

    // 3: both requesters held continuously, grants must alternate 0,1,0,1
    push_read(0, 32'h200, 32'hB0, 1'b0, mk_line(32'hB0));
    push_read(1, 32'h280, 32'hD0, 1'b0, mk_line(32'hD0));
    push_read(0, 32'h200, 32'hE0, 1'b0, mk_line(32'hE0));
    push_read(1, 32'h280, 32'hF0, 1'b0, mk_line(32'hF0));
    @(negedge fpga_clk);
    req_addr = {32'h280, 32'h200}; req_read = 2'b11;
    n0 = 0; n1 = 0; k = 0;
    for (int i = 0; i < 200 && (n0 < 2 || n1 < 2); i++) begin
      @(negedge fpga_clk);
      if (req_resp[0]) begin
        if (k < 4) order[k] = 0;
        k++; n0++;
        if (n0 == 2) req_read[0] = 1'b0;
      end
      if (req_resp[1]) begin
        if (k < 4) order[k] = 1;
        k++; n1++;
        if (n1 == 2) req_read[1] = 1'b0;
      end
    end
    req_read = 2'b00;
    chk("t3_txn_count", LW'(k), LW'(4));
    for (int i = 0; i < 4; i++) chk("t3_grant_order", LW'(order[i]), LW'(i % 2));
    last_line = mk_line(32'hF0);

    // 4: error on the 4th read beat, then a normal read
    err_at = 3;
    push_read(1, 32'h300, 32'hC0, 1'b1, last_line);
    @(negedge fpga_clk);
    req_addr[2*ADW-1:ADW] = 32'h300; req_read[1] = 1'b1;
    wait_resp(1, 40, c1);
    err_at = -1;
    push_read(0, 32'h340, 32'h60, 1'b0, mk_line(32'h60));
    @(negedge fpga_clk);
    req_addr[ADW-1:0] = 32'h340; req_read[0] = 1'b1;
    wait_resp(0, 40, c1);
    last_line = mk_line(32'h60);

    // 5: read with no return beats -> watchdog error
    mute = 1;
    push_read(0, 32'h400, 32'h00, 1'b1, last_line);
    @(negedge fpga_clk);
    req_addr[ADW-1:0] = 32'h400; req_read[0] = 1'b1; c0 = cycle;
    wait_resp(0, 60, c1);
    chk("t5_timeout_latency", LW'(c1 - c0), LW'(18));
    mute = 0;
    @(negedge fpga_clk);
    chk("t5_back_to_idle", LW'(busy), LW'(0));

    // 6: async reset during WDATA, then a fresh read
    ren_mode = 1;
    push_write(1, 32'h500, 32'h70, last_line);
    @(negedge fpga_clk);
    req_addr[2*ADW-1:ADW] = 32'h500; req_wdata[2*LW-1:LW] = mk_line(32'h70); req_write[1] = 1'b1;
    for (int i = 0; i < 30 && !data_on; i++) @(negedge fpga_clk);
    chk("t6_in_wdata", LW'(data_on), LW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", LW'({busy, address_on, data_on, read_en, write_en, fifo_empty,
                               req_resp, req_err, bus_c2m}), LW'({6'b000001, 4'b0000, 32'h0}));
    chk("t6_reset_rdata", req_rdata, LW'(0));
    req_write = 2'b00; req_read = 2'b00;
    exp_beat.delete(); exp_resp.delete(); rd_q.delete();
    ren_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fpga_clk);
      chk("t6_no_resp_in_reset", LW'(req_resp), LW'(0));
    end
    rst_n = 1'b1;
    @(negedge fpga_clk);
    push_read(0, 32'h600, 32'h90, 1'b0, mk_line(32'h90));
    @(negedge fpga_clk);
    req_addr[ADW-1:0] = 32'h600; req_read[0] = 1'b1;
    wait_resp(0, 40, c1);

    repeat (3) @(negedge fpga_clk);
    chk("end_beats_drained", LW'(exp_beat.size()), LW'(0));
    chk("end_resps_drained", LW'(exp_resp.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
